fwd_operand_stage: RTL and testbench

- Bypass-operand selector plus enable-gated pipeline register for the execute boundary of the 5-stage core.
- Two independent forwarding muxes choose each source operand from:
  - the register-file read value,
  - the memory-stage ALU result,
  - the writeback result.
- Muxed operands and a sideband payload are captured in a resettable, stall-able register feeding the next stage.

---
 rtl/fwd_operand_stage_if.sv | 43 ++++
 rtl/fwd_operand_stage.sv | 68 ++++++
 tb/tb_fwd_operand_stage.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_operand_stage_if.sv
// Operand-stage bundle: register-file reads, bypass sources, selects and registered outputs.
// With FWD_FLUSH_EN defined, the bundle also carries the flush input.
interface fwd_operand_stage_if #(
  parameter int WIDTH     = 32,
  parameter int PAYLOAD_W = 12
);
  logic                 en;
  logic [WIDTH-1:0]     rs1;
  logic [WIDTH-1:0]     rs2;
  logic [WIDTH-1:0]     aluResultM;
  logic [WIDTH-1:0]     resultW;
  logic                 validM;
  logic                 validW;
  logic [1:0]           forward1;
  logic [1:0]           forward2;
  logic [PAYLOAD_W-1:0] payloadD;
  logic [WIDTH-1:0]     fwd1;
  logic [WIDTH-1:0]     fwd2;
  logic [WIDTH-1:0]     fwd1Q;
  logic [WIDTH-1:0]     fwd2Q;
  logic [PAYLOAD_W-1:0] payloadQ;
`ifdef FWD_FLUSH_EN
  logic                 flush;
`endif

  modport master (
    output en, rs1, rs2, aluResultM, resultW, validM, validW,
           forward1, forward2, payloadD,
`ifdef FWD_FLUSH_EN
           flush,
`endif
    input  fwd1, fwd2, fwd1Q, fwd2Q, payloadQ
  );

  modport slave (
    input  en, rs1, rs2, aluResultM, resultW, validM, validW,
           forward1, forward2, payloadD,
`ifdef FWD_FLUSH_EN
           flush,
`endif
    output fwd1, fwd2, fwd1Q, fwd2Q, payloadQ
  );
endinterface

// File: rtl/fwd_operand_stage.sv
// Execute-boundary bypass muxes for two operands plus an enable-gated, async-reset capture register.
// Optional FWD_FLUSH_EN adds a synchronous flush that zeroes the register, with priority over en.
module fwd_operand_stage #(
  parameter int WIDTH     = 32,
  parameter int PAYLOAD_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  fwd_operand_stage_if.slave   bus
);

  localparam int REG_W = 2 * WIDTH + PAYLOAD_W;

  // Bypass source is used only when its valid is set; reserved select and
  // invalid bypass both fall back to the register-file value.
  function automatic logic [WIDTH-1:0] fwd_sel(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] rs,
    input logic [WIDTH-1:0] alu_m,
    input logic             vld_m,
    input logic [WIDTH-1:0] res_w,
    input logic             vld_w
  );
    logic [WIDTH-1:0] r;
    r = rs;
    case (sel)
      2'b01:   if (vld_w == 1'b1) r = res_w;
      2'b10:   if (vld_m == 1'b1) r = alu_m;
      default: r = rs;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] w_fwd1_p0;
  logic [WIDTH-1:0] w_fwd2_p0;
  logic [REG_W-1:0] w_d_p0;
  logic [REG_W-1:0] r_q_p1;

  // Stage p0: combinational forwarding
  always_comb begin
    w_fwd1_p0 = fwd_sel(bus.forward1, bus.rs1, bus.aluResultM, bus.validM,
                        bus.resultW, bus.validW);
    w_fwd2_p0 = fwd_sel(bus.forward2, bus.rs2, bus.aluResultM, bus.validM,
                        bus.resultW, bus.validW);
    w_d_p0    = {w_fwd1_p0, w_fwd2_p0, bus.payloadD};
  end

  assign bus.fwd1 = w_fwd1_p0;
  assign bus.fwd2 = w_fwd2_p0;

  // Stage p1: capture register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q_p1 <= '0;
`ifdef FWD_FLUSH_EN
    end else if (bus.flush) begin
      r_q_p1 <= '0;
`endif
    end else if (bus.en) begin
      r_q_p1 <= w_d_p0;
    end
  end

  assign bus.fwd1Q    = r_q_p1[REG_W-1 -: WIDTH];
  assign bus.fwd2Q    = r_q_p1[PAYLOAD_W +: WIDTH];
  assign bus.payloadQ = r_q_p1[PAYLOAD_W-1:0];

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Directed self-checking bench for fwd_operand_stage; define FWD_FLUSH_EN to exercise flush.
module tb_fwd_operand_stage;

  localparam int WIDTH     = 32;
  localparam int PAYLOAD_W = 12;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  fwd_operand_stage_if #(.WIDTH(WIDTH), .PAYLOAD_W(PAYLOAD_W)) bus ();

  fwd_operand_stage #(.WIDTH(WIDTH), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  task automatic drive_idle();
    bus.en         = 1'b0;
    bus.rs1        = '0;
    bus.rs2        = '0;
    bus.aluResultM = '0;
    bus.resultW    = '0;
    bus.validM     = 1'b0;
    bus.validW     = 1'b0;
    bus.forward1   = 2'b00;
    bus.forward2   = 2'b00;
    bus.payloadD   = '0;
`ifdef FWD_FLUSH_EN
    bus.flush      = 1'b0;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    bus.en  = 1'b1;
    bus.rs1 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    n_checks++;
    if (bus.fwd1Q !== 32'h0) begin
      n_errors++; $display("FAIL reset_fwd1Q: got %h expected %h", bus.fwd1Q, 32'h0);
    end
    n_checks++;
    if (bus.fwd1 !== 32'hFFFF_FFFF) begin
      n_errors++; $display("FAIL reset_fwd1_comb: got %h expected %h", bus.fwd1, 32'hFFFF_FFFF);
    end
    @(negedge clk);
    reset   = 1'b0;
    bus.rs1 = 32'h1234;
    bus.rs2 = 32'h5678;
    bus.payloadD = 12'h3C5;
    @(posedge clk); #1;
    n_checks++;
    if (bus.fwd1Q !== 32'h1234 || bus.fwd2Q !== 32'h5678 || bus.payloadQ !== 12'h3C5) begin
      n_errors++;
      $display("FAIL reset_first_load: got %h %h %h expected 00001234 00005678 3c5",
               bus.fwd1Q, bus.fwd2Q, bus.payloadQ);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.fwd1Q !== 32'h0 || bus.fwd2Q !== 32'h0 || bus.payloadQ !== 12'h0) begin
      n_errors++;
      $display("FAIL reset_async: got %h %h %h expected all zero", bus.fwd1Q, bus.fwd2Q, bus.payloadQ);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.fwd1Q !== 32'h0 || bus.payloadQ !== 12'h0) begin
      n_errors++;
      $display("FAIL reset_hold_en: got %h %h expected zero", bus.fwd1Q, bus.payloadQ);
    end
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
  endtask

  task automatic test_select();
    logic [WIDTH-1:0] exp_tab [4];
    exp_tab[0] = 32'h11; exp_tab[1] = 32'h22; exp_tab[2] = 32'h33; exp_tab[3] = 32'h11;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      bus.en = 1'b1;
      bus.rs1 = 32'h11; bus.resultW = 32'h22; bus.aluResultM = 32'h33;
      bus.validM = 1'b1; bus.validW = 1'b1;
      bus.forward1 = s[1:0];
      #1;
      n_checks++;
      if (bus.fwd1 !== exp_tab[s]) begin
        n_errors++; $display("FAIL select_comb sel=%0d: got %h expected %h", s, bus.fwd1, exp_tab[s]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.fwd1Q !== exp_tab[s]) begin
        n_errors++; $display("FAIL select_reg sel=%0d: got %h expected %h", s, bus.fwd1Q, exp_tab[s]);
      end
    end
    drive_idle();
  endtask

  task automatic test_validity();
    @(negedge clk);
    bus.forward2 = 2'b10; bus.validM = 1'b0; bus.rs2 = 32'h55; bus.aluResultM = 32'h99;
    #1;
    n_checks++;
    if (bus.fwd2 !== 32'h55) begin
      n_errors++; $display("FAIL valid_m_low: got %h expected %h", bus.fwd2, 32'h55);
    end
    bus.validM = 1'b1;
    #1;
    n_checks++;
    if (bus.fwd2 !== 32'h99) begin
      n_errors++; $display("FAIL valid_m_high: got %h expected %h", bus.fwd2, 32'h99);
    end
    bus.forward2 = 2'b01; bus.resultW = 32'h77; bus.validW = 1'b0;
    #1;
    n_checks++;
    if (bus.fwd2 !== 32'h55) begin
      n_errors++; $display("FAIL valid_w_low: got %h expected %h", bus.fwd2, 32'h55);
    end
    bus.forward2 = 2'b11; bus.validW = 1'b1;
    #1;
    n_checks++;
    if (bus.fwd2 !== 32'h55) begin
      n_errors++; $display("FAIL reserved_sel2: got %h expected %h", bus.fwd2, 32'h55);
    end
    drive_idle();
  endtask

  task automatic test_x_isolation();
    @(negedge clk);
    bus.rs1 = 32'hA5A5_0001; bus.rs2 = 32'h0BAD_F00D;
    bus.resultW = 'x; bus.aluResultM = 32'hC0DE_0002; bus.validM = 1'b1; bus.validW = 1'b1;
    bus.forward1 = 2'b10; bus.forward2 = 2'b00;
    #1;
    n_checks++;
    if (bus.fwd1 !== 32'hC0DE_0002 || bus.fwd2 !== 32'h0BAD_F00D) begin
      n_errors++; $display("FAIL x_isolation: got %h %h expected c0de0002 0badf00d", bus.fwd1, bus.fwd2);
    end
    bus.aluResultM = 'x; bus.resultW = 32'h0; bus.forward1 = 2'b01; bus.validW = 1'b0;
    #1;
    n_checks++;
    if (bus.fwd1 !== 32'hA5A5_0001) begin
      n_errors++; $display("FAIL x_isolation_gated: got %h expected %h", bus.fwd1, 32'hA5A5_0001);
    end
    drive_idle();
  endtask

  task automatic test_stall();
    @(negedge clk);
    bus.en = 1'b1; bus.payloadD = 12'hABC;
    @(posedge clk); #1;
    n_checks++;
    if (bus.payloadQ !== 12'hABC) begin
      n_errors++; $display("FAIL stall_load: got %h expected %h", bus.payloadQ, 12'hABC);
    end
    @(negedge clk);
    bus.en = 1'b0; bus.payloadD = 12'h123;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.payloadQ !== 12'hABC) begin
        n_errors++; $display("FAIL stall_hold cyc=%0d: got %h expected %h", c, bus.payloadQ, 12'hABC);
      end
    end
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.payloadQ !== 12'h123) begin
      n_errors++; $display("FAIL stall_release: got %h expected %h", bus.payloadQ, 12'h123);
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.en = 1'b1; bus.forward1 = 2'b01; bus.forward2 = 2'b01;
    bus.resultW = 32'hDEAD_BEEF; bus.validW = 1'b1;
    bus.rs1 = 32'h1; bus.rs2 = 32'h2;
    #1;
    n_checks++;
    if (bus.fwd1 !== 32'hDEAD_BEEF || bus.fwd2 !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL simul_comb: got %h %h expected deadbeef", bus.fwd1, bus.fwd2);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.fwd1Q !== 32'hDEAD_BEEF || bus.fwd2Q !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL simul_reg: got %h %h expected deadbeef", bus.fwd1Q, bus.fwd2Q);
    end
    @(negedge clk);
    bus.forward1 = 2'b00; bus.forward2 = 2'b10; bus.aluResultM = 32'h600D_CAFE; bus.validM = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.fwd1Q !== 32'h1 || bus.fwd2Q !== 32'h600D_CAFE) begin
      n_errors++; $display("FAIL b2b_reg: got %h %h expected 00000001 600dcafe", bus.fwd1Q, bus.fwd2Q);
    end
    drive_idle();
  endtask

`ifdef FWD_FLUSH_EN
  task automatic test_flush();
    for (int e = 1; e >= 0; e--) begin
      @(negedge clk);
      bus.en = 1'b1; bus.rs1 = 32'hCAFE; bus.rs2 = 32'hBEEF; bus.payloadD = 12'h5A5;
      @(posedge clk); #1;
      n_checks++;
      if (bus.fwd1Q !== 32'hCAFE || bus.payloadQ !== 12'h5A5) begin
        n_errors++; $display("FAIL flush_preload en=%0d: got %h %h expected 0000cafe 5a5", e, bus.fwd1Q, bus.payloadQ);
      end
      @(negedge clk);
      bus.en = e[0]; bus.flush = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (bus.fwd1Q !== 32'h0 || bus.fwd2Q !== 32'h0 || bus.payloadQ !== 12'h0) begin
        n_errors++; $display("FAIL flush en=%0d: got %h %h %h expected zero", e, bus.fwd1Q, bus.fwd2Q, bus.payloadQ);
      end
      @(negedge clk);
      bus.flush = 1'b0;
    end
    drive_idle();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_select();
    test_validity();
    test_x_isolation();
    test_stall();
    test_back_to_back();
`ifdef FWD_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
